// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, load-size encodings and FSM states for the write-back stage
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REGIDX = 5;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_COMMIT   = 2'b10
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational load data alignment and sign/zero extension
module load_extend
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      byte_off_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    // A half at offset 3 naturally picks up zero fill in its upper byte from the shift.
    always_comb begin
        shifted = rdata_i >> {byte_off_i, 3'b000};
        case (size_i)
            LS_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            LS_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: commits ALU results or extended load data to the register file
// Optional WB_BYPASS_EN adds a forwarding path from the committing write to the decode operands.
module wb_stage
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REGIDX-1:0] in_rd,
    input  logic              in_reg_wr,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic              in_is_load,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [1:0]        in_byte_off,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REGIDX-1:0] reg_write_addr,
    output logic [XLEN-1:0]   reg_write_data,
    output logic              reg_wr
`ifdef WB_BYPASS_EN
    ,
    input  logic [REGIDX-1:0] id_ra,
    input  logic [REGIDX-1:0] id_rb,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    wb_state_e         state_q, state_d;
    logic [REGIDX-1:0] rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;

    logic              in_ready_q, in_ready_d;
    logic              reg_wr_q, reg_wr_d;
    logic [REGIDX-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic              accept;
    logic [XLEN-1:0]   ext_data;

    logic              commit;
    logic              commit_we;
    logic [REGIDX-1:0] commit_rd;
    logic [XLEN-1:0]   commit_data;

    assign accept = in_valid && in_ready_q;

    load_extend u_load_extend (
        .rdata_i    (mem_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .byte_off_i (off_q),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            size_q     <= LS_WORD;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            in_ready_q <= 1'b1;
            reg_wr_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            in_ready_q <= in_ready_d;
            reg_wr_q   <= reg_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                if (accept)
                    state_d = in_is_load ? S_WAIT_MEM : S_COMMIT;
                else
                    state_d = S_IDLE;
            end
            S_WAIT_MEM: begin
                if (mem_rvalid)
                    state_d = S_COMMIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address/data only move on a real write so they hold the last committed values otherwise.
    always_comb begin
        rd_d        = rd_q;
        wr_d        = wr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        commit      = 1'b0;
        commit_we   = 1'b0;
        commit_rd   = '0;
        commit_data = '0;

        if (state_q != S_WAIT_MEM && accept) begin
            rd_d   = in_rd;
            wr_d   = in_reg_wr;
            size_d = in_load_size;
            uns_d  = in_load_unsigned;
            off_d  = in_byte_off;
            if (!in_is_load) begin
                commit      = 1'b1;
                commit_we   = in_reg_wr;
                commit_rd   = in_rd;
                commit_data = in_alu_result;
            end
        end else if (state_q == S_WAIT_MEM && mem_rvalid) begin
            commit      = 1'b1;
            commit_we   = wr_q;
            commit_rd   = rd_q;
            commit_data = ext_data;
        end

        in_ready_d = (state_d != S_WAIT_MEM);
        reg_wr_d   = commit && commit_we && (commit_rd != '0);
        addr_d     = reg_wr_d ? commit_rd : addr_q;
        data_d     = reg_wr_d ? commit_data : data_q;
    end

    assign in_ready       = in_ready_q;
    assign reg_wr         = reg_wr_q;
    assign reg_write_addr = addr_q;
    assign reg_write_data = data_q;

`ifdef WB_BYPASS_EN
    assign fwd_a    = reg_wr_q && (addr_q == id_ra) && (id_ra != '0);
    assign fwd_b    = reg_wr_q && (addr_q == id_rb) && (id_rb != '0);
    assign fwd_data = data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_wr;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [1:0]  in_byte_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        reg_wr;
`ifdef WB_BYPASS_EN
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_rd            (in_rd),
        .in_reg_wr        (in_reg_wr),
        .in_alu_result    (in_alu_result),
        .in_is_load       (in_is_load),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_byte_off      (in_byte_off),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .reg_wr           (reg_wr)
`ifdef WB_BYPASS_EN
        ,
        .id_ra            (id_ra),
        .id_rb            (id_rb),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .fwd_data         (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] alu);
        in_valid      = 1'b1;
        in_is_load    = 1'b0;
        in_reg_wr     = 1'b1;
        in_rd         = rd;
        in_alu_result = alu;
    endtask

    // Accept a load, wait the given cycles, return data, check the commit, return to idle.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] size,
                           input logic uns, input logic [1:0] off, input logic [31:0] rdata,
                           input int waits, input logic [31:0] exp);
        in_valid         = 1'b1;
        in_is_load       = 1'b1;
        in_reg_wr        = 1'b1;
        in_rd            = rd;
        in_load_size     = size;
        in_load_unsigned = uns;
        in_byte_off      = off;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < waits; w++) begin
            chk({tag, "_ready_wait"}, {31'b0, in_ready}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, "_wr"}, {31'b0, reg_wr}, 32'd1);
        chk({tag, "_addr"}, {27'b0, reg_write_addr}, {27'b0, rd});
        chk({tag, "_data"}, reg_write_data, exp);
        tick();
        chk({tag, "_wr_after"}, {31'b0, reg_wr}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_wr = 1'b0; in_alu_result = '0;
        in_is_load = 1'b0; in_load_size = 2'b10; in_load_unsigned = 1'b0; in_byte_off = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef WB_BYPASS_EN
        id_ra = '0; id_rb = '0;
`endif
        tick();
        tick();
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_wr", {31'b0, reg_wr}, 32'd0);
        chk("rst_addr", {27'b0, reg_write_addr}, 32'd0);
        chk("rst_data", reg_write_data, 32'd0);
        rst = 1'b0;

        drive_alu(5'd5, 32'h1234_5678);
        tick();
        in_valid = 1'b0;
        chk("alu_wr", {31'b0, reg_wr}, 32'd1);
        chk("alu_addr", {27'b0, reg_write_addr}, 32'd5);
        chk("alu_data", reg_write_data, 32'h1234_5678);
        tick();
        chk("alu_wr_n2", {31'b0, reg_wr}, 32'd0);
        chk("alu_hold_data", reg_write_data, 32'h1234_5678);

        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_wr", {31'b0, reg_wr}, 32'd0);
        chk("stray_rvalid_ready", {31'b0, in_ready}, 32'd1);

        do_load("lb_s", 5'd6, 2'b00, 1'b0, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80);
        do_load("lb_u", 5'd6, 2'b00, 1'b1, 2'd2, 32'h0080_0000, 3, 32'h0000_0080);
        do_load("lh_off3", 5'd7, 2'b01, 1'b0, 2'd3, 32'hF000_0000, 1, 32'h0000_00F0);
        do_load("lh_off2", 5'd8, 2'b01, 1'b0, 2'd2, 32'h8001_0000, 0, 32'hFFFF_8001);
        do_load("lw_off1", 5'd9, 2'b10, 1'b0, 2'd1, 32'hA5A5_1234, 2, 32'hA5A5_1234);

        drive_alu(5'd0, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0;
        chk("rd0_wr", {31'b0, reg_wr}, 32'd0);
        chk("rd0_addr", {27'b0, reg_write_addr}, 32'd9);
        chk("rd0_data", reg_write_data, 32'hA5A5_1234);
        chk("rd0_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("rd0_wr_after", {31'b0, reg_wr}, 32'd0);

        for (int i = 1; i <= 4; i++) begin
            drive_alu(5'(i), 32'h1111_1111 * i);
            tick();
            chk("b2b_wr", {31'b0, reg_wr}, 32'd1);
            chk("b2b_addr", {27'b0, reg_write_addr}, i);
            chk("b2b_data", reg_write_data, 32'h1111_1111 * i);
            chk("b2b_ready", {31'b0, in_ready}, 32'd1);
`ifdef WB_BYPASS_EN
            if (i == 4) begin
                id_ra = 5'd4; id_rb = 5'd3;
                #1;
                chk("fwd_a", {31'b0, fwd_a}, 32'd1);
                chk("fwd_b", {31'b0, fwd_b}, 32'd0);
                chk("fwd_data", fwd_data, 32'h4444_4444);
                id_ra = '0; id_rb = '0;
            end
`endif
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_wr", {31'b0, reg_wr}, 32'd0);

        in_valid = 1'b1; in_is_load = 1'b1; in_reg_wr = 1'b1; in_rd = 5'd10;
        in_load_size = 2'b10; in_byte_off = 2'd0;
        tick();
        in_valid = 1'b0;
        chk("rstw_ready_wait", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        drive_alu(5'd3, 32'h0BAD_0BAD);
        tick();
        chk("rstw_ready", {31'b0, in_ready}, 32'd1);
        chk("rstw_wr", {31'b0, reg_wr}, 32'd0);
        chk("rstw_data", reg_write_data, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rstw_post_wr", {31'b0, reg_wr}, 32'd0);
        chk("rstw_post_addr", {27'b0, reg_write_addr}, 32'd0);
        chk("rstw_post_ready", {31'b0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port `in_valid`, input, 1 bit: upstream (MEM) result valid.
REQ-004 SHALL have port `in_ready`, output, 1 bit: stage can accept a result this cycle.
REQ-005 SHALL have port `in_rd`, input, 5 bits: destination register index.
REQ-006 SHALL have port `in_reg_wr`, input, 1 bit: instruction writes the register file.
REQ-007 SHALL have port `in_alu_result`, input, 32 bits: execute result.
REQ-008 SHALL have port `in_is_load`, input, 1 bit: result comes from memory.
REQ-009 SHALL have port `in_load_size`, input, 2 bits: 00 byte, 01 half, 10/11 word.
REQ-010 SHALL have port `in_load_unsigned`, input, 1 bit: zero-extend instead of sign-extend.
REQ-011 SHALL have port `in_byte_off`, input, 2 bits: load address[1:0].
REQ-012 SHALL have port `mem_rvalid`, input, 1 bit: load data returned.
REQ-013 SHALL have port `mem_rdata`, input, 32 bits: returned word.
REQ-014 SHALL have port `reg_write_addr`, output, 5 bits: register-file write index.
REQ-015 SHALL have port `reg_write_data`, output, 32 bits: register-file write data.
REQ-016 SHALL have port `reg_wr`, output, 1 bit: register-file write enable.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_MEM and COMMIT.
REQ-018 SHALL drive `in_ready` = 1 in IDLE and COMMIT, and 0 in WAIT_MEM.
REQ-019 SHALL accept a result on `in_valid && in_ready`, capturing rd, reg_wr and the load controls.
REQ-020 SHALL, on acceptance of a non-load, capture `in_alu_result` and go to COMMIT (1-cycle latency).
REQ-021 SHALL, on acceptance of a load, go to WAIT_MEM.
REQ-022 SHALL, in WAIT_MEM with `mem_rvalid`=1, capture the extended data and go to COMMIT.
REQ-023 SHALL ignore `mem_rvalid` outside WAIT_MEM.
REQ-024 SHALL, in COMMIT, go to WAIT_MEM or COMMIT on a new acceptance, otherwise to IDLE; back-to-back non-loads SHALL sustain 1 per cycle.
REQ-025 SHALL register all outputs.
REQ-026 SHALL assert `reg_wr` only in COMMIT, equal to captured reg_wr && rd != 0.
REQ-027 SHALL still complete the COMMIT cycle for rd = 0, with write suppressed.
REQ-028 SHALL make `reg_write_addr` and `reg_write_data` hold the last committed values outside COMMIT.
REQ-029 SHALL perform load extension as: shifted = mem_rdata >> (8*byte_off).
REQ-030 SHALL, for byte loads, take shifted[7:0] and sign- or zero-extend it.
REQ-031 SHALL, for half loads, take shifted[15:0] and sign- or zero-extend it.
REQ-032 SHALL, for word loads, use `mem_rdata` unchanged, ignoring byte_off.
REQ-033 SHALL, for a half load at byte_off = 3, form the half as {8'h00, mem_rdata[31:24]} before extension.

Reset
REQ-034 SHALL, while `rst`=1 at an edge, set state to IDLE and set `reg_wr`, `reg_write_addr` and `reg_write_data` to 0.
REQ-035 SHALL drive `in_ready`=1 during reset.
REQ-036 SHALL, on reset in WAIT_MEM or COMMIT, discard the pending result with no write.
REQ-037 SHALL ignore `in_valid` in a cycle where `rst`=1.

Configuration
REQ-038 SHALL, with `WB_BYPASS_EN` defined, add input ports `id_ra` (5 bits) and `id_rb` (5 bits).
REQ-039 SHALL, with `WB_BYPASS_EN` defined, add output ports `fwd_a` (1 bit), `fwd_b` (1 bit) and `fwd_data` (32 bits).
REQ-040 SHALL, with `WB_BYPASS_EN` defined, compute `fwd_a` combinationally as reg_wr && reg_write_addr == id_ra && id_ra != 0, and `fwd_b` likewise with `id_rb`.
REQ-041 SHALL, with `WB_BYPASS_EN` defined, drive `fwd_data` = `reg_write_data`.
REQ-042 SHALL, without `WB_BYPASS_EN`, omit those ports and logic entirely.

Structure
REQ-043 SHALL place in shared package `wb_pkg`: XLEN=32, REGIDX=5, load-size encodings (LS_BYTE, LS_HALF, LS_WORD) and the FSM state enum.
REQ-044 SHALL implement load extension in combinational sub-module `load_extend` (inputs rdata, size, unsigned, byte_off; output data).

Verification
REQ-045 SHALL cover: non-load rd=5, alu=32'h1234_5678 accepted at cycle N -> cycle N+1 reg_wr=1, addr=5, data=32'h1234_5678; cycle N+2 reg_wr=0.
REQ-046 SHALL cover: byte load, signed, off=2, mem_rdata=32'h00_80_00_00 after 3 wait cycles -> in_ready=0 while waiting; next cycle data=32'hFFFF_FF80; unsigned variant -> 32'h0000_0080.
REQ-047 SHALL cover: half load at off=3, signed, mem_rdata=32'hF0_00_00_00 -> data=32'h0000_00F0.
REQ-048 SHALL cover: non-load rd=0, alu=32'hDEAD_BEEF -> reg_wr stays 0; outputs hold previous values.
REQ-049 SHALL cover: 4 back-to-back non-loads rd=1..4 -> reg_wr high 4 consecutive cycles, in_ready constantly 1.
REQ-050 SHALL cover: rst asserted in WAIT_MEM, then mem_rvalid -> no write; state IDLE; in_ready=1; with WB_BYPASS_EN, id_ra=4 during the rd=4 COMMIT -> fwd_a=1, fwd_data matches.
